param_delay_line: RTL
=====================

Name: param_delay_line

Overview:
- Parametrised successor to the fixed 8-bit/6-deep receive-path sample shift register: generalised width, depth and channel count.
- Adds fill tracking, a flush, a registered tap read port with range checking, and an optional per-channel moving sum.
- Sits in the inband receive path between sample strobe generation and packet/filter logic.

Parameters:
- WIDTH, 16, bits per sample per channel.
- DEPTH, 8, taps per channel (2..64).
- CHANNELS, 2, independent delay lines sharing one strobe (1..4).
- SELW, 6, tap-select width; must satisfy 2^SELW >= DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rxstrobe  in  1  shift enable; one sample per channel per strobe.
- flush  in  1  synchronous clear of contents and fill count.
- in_sample  in  CHANNELS*WIDTH  new samples; channel c at bits [c*WIDTH +: WIDTH].
- out_sample  out  CHANNELS*WIDTH  oldest tap (DEPTH-1) of each channel, combinational from storage.
- out_valid  out  1  high when fill == DEPTH.
- fill  out  $clog2(DEPTH+1)  number of valid samples held.
- sel  in  SELW  tap index; 0 = newest, DEPTH-1 = oldest.
- ch  in  2  channel index for tap read.
- rd_en  in  1  tap read request.
- data  out  WIDTH  registered tap read result.
- data_valid  out  1  one-cycle pulse, cycle after rd_en.
- sel_err  out  1  one-cycle pulse with data_valid when sel >= DEPTH or ch >= CHANNELS.

Behaviour:
- Reset (reset low, asynchronous): all taps, fill, data, data_valid and sel_err are 0. out_sample is 0 and out_valid is 0.
- Shift on rising clk with rxstrobe=1 and flush=0, per channel:
  - tap[k] <= tap[k-1] for k = 1..DEPTH-1.
  - tap[0] <= in_sample slice.
  - fill increments, saturating at DEPTH.
- flush=1 has priority over rxstrobe: all taps and fill go to 0 next cycle. A strobe in the same cycle is dropped.
- out_sample and out_valid follow storage with zero additional latency. out_valid asserts the cycle after the DEPTH-th strobe following reset/flush.
- Tap read has 1-cycle latency. With rd_en=1 at edge N:
  - at N+1: data = tap[sel] of channel ch, sampled before any shift occurring at edge N (pre-shift value); data_valid = 1.
  - Out-of-range sel or ch: data = 0 and sel_err = 1.
  - Taps with index >= fill read as stored (0 after reset/flush); this is not an error.
  - When rd_en=0, data holds its last value and data_valid = 0.
- Simultaneous rd_en and flush: the read returns pre-flush contents.
- Reset asserted mid-operation clears everything immediately. The first post-reset edge with rxstrobe loads tap[0] and sets fill = 1.

Optional Feature:
- Macro: DELAY_LINE_SUM_EN.
- Defined: adds output sum (CHANNELS*(WIDTH+$clog2(DEPTH)) bits), one running sum of all DEPTH taps per channel, samples treated as two's-complement signed.
  - Update on each accepted strobe: sum <= sum + in - tap[DEPTH-1], sign-extended.
  - Reset and flush clear sums to 0.
  - sum is registered, so it is valid the same cycle the taps update.
- Undefined: port absent, no adder logic.

Test Plan:
- Reset, then strobe in 1..8 on ch0 (DEPTH=8) -> fill 1..8; out_valid rises after the 8th strobe; out_sample ch0 = 1.
- Strobe a 9th sample 9 -> out_sample ch0 = 2; fill stays 8; read sel=0, ch=0 -> data = 9, data_valid pulse one cycle later.
- rd_en with sel=8 or ch=3 (CHANNELS=2) -> data = 0, sel_err = 1 for exactly one cycle.
- rxstrobe and flush asserted together after filling -> all taps 0, fill 0, out_valid 0; rd_en in the same cycle returns the pre-flush tap value.
- Assert reset low mid-stream between clock edges -> outputs 0 immediately without a clock edge; the next strobe gives fill = 1.
- DELAY_LINE_SUM_EN defined: feed 8 samples of -3 then 8 samples of +5 -> sum ch0 = -24, then +40; flush -> 0.

Source files
------------

// File: rtl/param_delay_line.sv
// Multi-channel sample delay line with fill tracking, flush and a registered tap read port.
// Optional per-channel signed moving sum enabled by defining DELAY_LINE_SUM_EN.
module param_delay_line #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int CHANNELS = 2,
   parameter int SELW     = 6
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rxstrobe,
   input  logic                          flush,
   input  logic [CHANNELS*WIDTH-1:0]     in_sample,
   output logic [CHANNELS*WIDTH-1:0]     out_sample,
   output logic                          out_valid,
   output logic [$clog2(DEPTH+1)-1:0]    fill,
   input  logic [SELW-1:0]               sel,
   input  logic [1:0]                    ch,
   input  logic                          rd_en,
   output logic [WIDTH-1:0]              data,
   output logic                          data_valid,
   output logic                          sel_err
`ifdef DELAY_LINE_SUM_EN
   ,
   output logic [CHANNELS*(WIDTH+$clog2(DEPTH))-1:0] sum
`endif
);

   localparam int FW = $clog2(DEPTH+1);
   localparam int SW = WIDTH + $clog2(DEPTH);

   logic [WIDTH-1:0] taps [CHANNELS][DEPTH];
   logic [WIDTH-1:0] rd_word_p0;
   logic             rd_bad_p0;
   logic [WIDTH-1:0] data_p1;
   logic             vld_p1;
   logic             err_p1;

   function automatic logic [FW-1:0] fill_inc(input logic [FW-1:0] f);
      return (f == FW'(DEPTH)) ? f : f + 1'b1;
   endfunction

   // Stage p0: sample storage and fill count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < DEPTH; k++)
               taps[c][k] <= '0;
         fill <= '0;
      end else if (flush) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < DEPTH; k++)
               taps[c][k] <= '0;
         fill <= '0;
      end else if (rxstrobe) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int k = DEPTH-1; k > 0; k--)
               taps[c][k] <= taps[c][k-1];
            taps[c][0] <= in_sample[c*WIDTH +: WIDTH];
         end
         fill <= fill_inc(fill);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign out_sample[g*WIDTH +: WIDTH] = taps[g][DEPTH-1];
   end

   assign out_valid = (fill == FW'(DEPTH));

   always_comb begin
      rd_word_p0 = '0;
      rd_bad_p0  = (32'(sel) >= DEPTH) || (32'(ch) >= CHANNELS);
      for (int c = 0; c < CHANNELS; c++)
         for (int k = 0; k < DEPTH; k++)
            if (ch == 2'(c) && sel == SELW'(k))
               rd_word_p0 = taps[c][k];
   end

   // Stage p1: registered tap read; sees contents before this edge's shift or flush
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
         err_p1  <= 1'b0;
      end else begin
         vld_p1 <= rd_en;
         err_p1 <= rd_en & rd_bad_p0;
         if (rd_en)
            data_p1 <= rd_bad_p0 ? '0 : rd_word_p0;
      end
   end

   assign data       = data_p1;
   assign data_valid = vld_p1;
   assign sel_err    = err_p1;

`ifdef DELAY_LINE_SUM_EN
   logic signed [SW-1:0] sums_p1 [CHANNELS];

   function automatic logic signed [SW-1:0] sext(input logic [WIDTH-1:0] x);
      return SW'($signed(x));
   endfunction

   // Stage p1: running sum tracks the tap contents in lockstep
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < CHANNELS; c++)
            sums_p1[c] <= '0;
      end else if (flush) begin
         for (int c = 0; c < CHANNELS; c++)
            sums_p1[c] <= '0;
      end else if (rxstrobe) begin
         for (int c = 0; c < CHANNELS; c++)
            sums_p1[c] <= sums_p1[c] + sext(in_sample[c*WIDTH +: WIDTH])
                          - sext(taps[c][DEPTH-1]);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_sum
      assign sum[g*SW +: SW] = sums_p1[g];
   end
`endif

endmodule
